ni_flit_injector: RTL and testbench

Network-interface-side flit transmitter that drives one switch input port (FLIT/VALID/FWDAUX1 forward, BWDAUX1..3 backward) of the 80-bit xpipes fabric. It accepts a packet descriptor (header flit plus payload length) and a stream of payload words from the NI core. It serialises them into header/body/tail flits and holds each flit stable under stall/go backpressure from the switch. It is the transmitting end of the link whose receiving end is the switch's `in_buffer_6`.

---
 rtl/noc_flit_pkg.sv | 16 +
 rtl/flit_tx_skid_fifo.sv | 58 +++++
 rtl/ni_flit_injector.sv | 122 ++++++++++++
 tb/tb_ni_flit_injector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - shared flit width, transmitter FSM states and output-FIFO entry type
package noc_flit_pkg;

    localparam int NOC_FLIT_WIDTH = 80;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [NOC_FLIT_WIDTH-1:0] flit;
        logic                      tail;
    } flit_entry_t;

endpackage

// File: rtl/flit_tx_skid_fifo.sv
// rtl/flit_tx_skid_fifo.sv - 2-entry register FIFO; head entry is always on data_o
module flit_tx_skid_fifo #(
    parameter int DW = 81
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o,
    output logic          room_o,
    output logic          empty_o
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] next_q;
    logic [1:0]    count_q;

    // Callers only pop when non-empty and only push when room_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            next_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= data_i;
                    end else begin
                        next_q <= data_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= next_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= data_i;
                    end else begin
                        head_q <= next_q;
                        next_q <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;
    assign room_o  = (count_q != 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ni_flit_injector.sv
// rtl/ni_flit_injector.sv - NI flit transmitter: descriptor + payload to stall/go flits (stats: NI_FLIT_INJECTOR_STATS_EN)
module ni_flit_injector
    import noc_flit_pkg::*;
#(
    parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [FLIT_WIDTH-1:0] pkt_header,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [FLIT_WIDTH-1:0] pld_data,
    output logic [FLIT_WIDTH-1:0] FLIT_out,
    output logic                  VALID_out,
    output logic                  FWDAUX1_out,
    input  logic                  BWDAUX1_in,
    input  logic                  BWDAUX2_in,
    input  logic                  BWDAUX3_in
`ifdef NI_FLIT_INJECTOR_STATS_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    tx_state_e             state_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    flit_entry_t           push_entry;
    flit_entry_t           head_entry;
    logic [1:0]            fifo_count_unused;
    logic                  room;
    logic                  empty;
    logic                  pkt_fire;
    logic                  pld_fire;
    logic                  push;
    logic                  pop;
    logic                  aux_unused;

    assign aux_unused = BWDAUX2_in ^ BWDAUX3_in;

    // Readies depend only on registered state, never on BWDAUX1_in.
    assign pkt_ready = (state_q == IDLE) && room;
    assign pld_ready = (state_q == BODY) && room;
    assign pkt_fire  = pkt_valid && pkt_ready;
    assign pld_fire  = pld_valid && pld_ready;
    assign push      = pkt_fire || pld_fire;
    assign pop       = !empty && !BWDAUX1_in;

    always_comb begin
        push_entry = '0;
        if (state_q == IDLE) begin
            push_entry.flit = pkt_header;
            push_entry.tail = (pkt_len == '0);
        end else begin
            push_entry.flit = pld_data;
            push_entry.tail = (remaining_q == LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pkt_fire) begin
                        remaining_q <= pkt_len;
                        if (pkt_len != '0) begin
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (pld_fire) begin
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    flit_tx_skid_fifo #(
        .DW($bits(flit_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .count_o (fifo_count_unused),
        .room_o  (room),
        .empty_o (empty)
    );

    assign FLIT_out    = head_entry.flit;
    assign FWDAUX1_out = head_entry.tail;
    assign VALID_out   = !empty;

`ifdef NI_FLIT_INJECTOR_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
        end else if (VALID_out && BWDAUX1_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb/tb_ni_flit_injector.sv - self-checking bench for ni_flit_injector against a queue-based link model
module tb_ni_flit_injector;

    localparam int FW = 80;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [FW-1:0] pkt_header;
    logic [LW-1:0] pkt_len;
    logic          pld_valid;
    logic          pld_ready;
    logic [FW-1:0] pld_data;
    logic [FW-1:0] FLIT_out;
    logic          VALID_out;
    logic          FWDAUX1_out;
    logic          BWDAUX1_in;
    logic          BWDAUX2_in;
    logic          BWDAUX3_in;
`ifdef NI_FLIT_INJECTOR_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    ni_flit_injector #(
        .FLIT_WIDTH (FW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_header  (pkt_header),
        .pkt_len     (pkt_len),
        .pld_valid   (pld_valid),
        .pld_ready   (pld_ready),
        .pld_data    (pld_data),
        .FLIT_out    (FLIT_out),
        .VALID_out   (VALID_out),
        .FWDAUX1_out (FWDAUX1_out),
        .BWDAUX1_in  (BWDAUX1_in),
        .BWDAUX2_in  (BWDAUX2_in),
        .BWDAUX3_in  (BWDAUX3_in)
`ifdef NI_FLIT_INJECTOR_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct { logic [FW-1:0] data; logic tail; } exp_t;
    typedef struct { logic [FW-1:0] hdr; logic [LW-1:0] len; } desc_t;
    typedef struct {
        int          npkt;
        int          len0;
        int          len1;
        logic [63:0] busy;
        int          exp_flits;
        int          exp_stalls;
    } vec_t;

    exp_t          exp_q[$];
    desc_t         desc_q[$];
    logic [FW-1:0] word_q[$];
    int            pld_left;
    int            checks;
    int            errors;
    int            model_stalls;
    int            transfers;
    int            gaps;
    bit            seen_valid;

    function automatic logic [FW-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    task automatic chk_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_packet(input int len, input logic [FW-1:0] hdr);
        desc_t d;
        d.hdr = hdr;
        d.len = LW'(len);
        desc_q.push_back(d);
        for (int i = 0; i < len; i++) word_q.push_back(rand_word());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        pkt_valid  = 1'b0;
        pld_valid  = 1'b0;
        pkt_header = '0;
        pkt_len    = '0;
        pld_data   = '0;
        BWDAUX1_in = 1'b0;
        BWDAUX2_in = 1'b0;
        BWDAUX3_in = 1'b0;
        exp_q.delete();
        desc_q.delete();
        word_q.delete();
        pld_left     = 0;
        model_stalls = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One link cycle: drive, compare against the model, then advance the model to the coming edge.
    task automatic do_cycle(input logic busy_v, input bit pv, input bit dv);
        exp_t e;
        desc_t d;
        @(negedge clk);
        BWDAUX1_in = busy_v;
        BWDAUX2_in = 1'($urandom());
        BWDAUX3_in = 1'($urandom());
        pkt_valid  = pv && (desc_q.size() > 0);
        if (desc_q.size() > 0) begin
            pkt_header = desc_q[0].hdr;
            pkt_len    = desc_q[0].len;
        end else begin
            pkt_header = rand_word();
            pkt_len    = LW'($urandom());
        end
        pld_valid = dv;
        pld_data  = (word_q.size() > 0) ? word_q[0] : rand_word();
        #1;
        chk_i("valid_out", int'(VALID_out), int'(exp_q.size() != 0));
        chk_i("pkt_ready", int'(pkt_ready), int'(pld_left == 0 && exp_q.size() < 2));
        chk_i("pld_ready", int'(pld_ready), int'(pld_left > 0 && exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            chk_w("flit_out", FLIT_out, exp_q[0].data);
            chk_i("tail_out", int'(FWDAUX1_out), int'(exp_q[0].tail));
            seen_valid = 1'b1;
            if (busy_v) model_stalls++;
        end else if (seen_valid && (desc_q.size() > 0 || pld_left > 0)) begin
            gaps++;
        end
        if ((pkt_valid && pkt_ready) || (pld_valid && pld_ready))
            chk_i("push_when_full", int'(exp_q.size() < 2), 1);
        if (exp_q.size() > 0 && !busy_v) begin
            void'(exp_q.pop_front());
            transfers++;
        end
        if (pld_valid && pld_ready && pld_left > 0 && word_q.size() > 0) begin
            e.data = word_q.pop_front();
            e.tail = (pld_left == 1);
            exp_q.push_back(e);
            pld_left--;
        end else if (pkt_valid && pkt_ready && desc_q.size() > 0) begin
            d = desc_q.pop_front();
            e.data = d.hdr;
            e.tail = (d.len == '0);
            exp_q.push_back(e);
            pld_left = int'(d.len);
        end
    endtask

    task automatic run_directed(input logic [63:0] busy_mask, input int bound);
        int c;
        c          = 0;
        gaps       = 0;
        transfers  = 0;
        seen_valid = 1'b0;
        while ((desc_q.size() > 0 || pld_left > 0 || exp_q.size() > 0) && c < bound) begin
            do_cycle((c < 64) ? busy_mask[c[5:0]] : 1'b0, 1'b1, 1'b1);
            c++;
        end
        chk_i("directed_timeout", int'(c < bound), 1);
    endtask

    vec_t vecs[6];

    initial begin
        int c;
        int total;
        checks = 0;
        errors = 0;
        rst    = 1'b0;

        vecs[0] = '{1, 0,  0, 64'h0,        1,  0};
        vecs[1] = '{1, 3,  0, 64'h0,        4,  0};
        vecs[2] = '{1, 3,  0, 64'h7C,       4,  5};
        vecs[3] = '{2, 1, 15, 64'h0,        18, 0};
        vecs[4] = '{1, 15, 0, 64'hAAAAAAAA, 16, 16};
        vecs[5] = '{1, 2,  0, 64'hFFFE,     3,  15};

        do_reset();
        #1;
        chk_i("rst_valid", int'(VALID_out), 0);
        chk_w("rst_flit", FLIT_out, '0);
        chk_i("rst_tail", int'(FWDAUX1_out), 0);
        chk_i("rst_pkt_ready", int'(pkt_ready), 1);
        chk_i("rst_pld_ready", int'(pld_ready), 0);
`ifdef NI_FLIT_INJECTOR_STATS_EN
        chk_i("rst_stall_cnt", int'(stall_cnt), 0);
`endif

        foreach (vecs[i]) begin
            do_reset();
            add_packet(vecs[i].len0, {rand_word() >> 8, 8'hA5} );
            if (vecs[i].npkt > 1) add_packet(vecs[i].len1, rand_word());
            run_directed(vecs[i].busy, 200);
            chk_i($sformatf("vec%0d_flits", i), transfers, vecs[i].exp_flits);
            chk_i($sformatf("vec%0d_gaps", i), gaps, 0);
            #2;
`ifdef NI_FLIT_INJECTOR_STATS_EN
            chk_i($sformatf("vec%0d_stall_cnt", i), int'(stall_cnt), vecs[i].exp_stalls);
`endif
        end

        // Reset in the middle of a 4-payload packet, then a clean packet.
        do_reset();
        add_packet(4, rand_word());
        c = 0;
        seen_valid = 1'b0;
        while (pld_left != 3 && c < 20) begin
            do_cycle(1'b0, 1'b1, 1'b1);
            c++;
        end
        chk_i("midrst_reach", int'(c < 20), 1);
        @(posedge clk);
        #2;
        chk_i("midrst_valid_before", int'(VALID_out), 1);
        rst = 1'b0;
        #1;
        chk_i("midrst_valid_async", int'(VALID_out), 0);
        exp_q.delete();
        desc_q.delete();
        word_q.delete();
        pld_left     = 0;
        model_stalls = 0;
        pkt_valid    = 1'b0;
        pld_valid    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_i("midrst_pkt_ready", int'(pkt_ready), 1);
        add_packet(2, rand_word());
        run_directed(64'h0, 50);
        chk_i("midrst_new_flits", transfers, 3);

        // Randomised traffic and backpressure over 1000 packets.
        do_reset();
        total = 0;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = int'($urandom_range(0, 15));
            add_packet(len, rand_word());
            total += len + 1;
        end
        transfers  = 0;
        seen_valid = 1'b0;
        c = 0;
        while ((desc_q.size() > 0 || pld_left > 0 || exp_q.size() > 0) && c < 80000) begin
            do_cycle($urandom_range(0, 99) < 30, ($urandom() % 4) != 0, ($urandom() % 4) != 0);
            c++;
        end
        chk_i("random_timeout", int'(c < 80000), 1);
        chk_i("random_flits", transfers, total);
        #2;
`ifdef NI_FLIT_INJECTOR_STATS_EN
        chk_i("random_stall_cnt", int'(stall_cnt), model_stalls);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
